button_conditioner: RTL and testbench

Front-end stage that turns the two raw duty-adjust push-buttons into clean, single-cycle `increase_duty` / `decrease_duty` command pulses for the PWM generator. Each button is synchronised, debounced and edge-detected, and auto-repeats while it is held. It sits between the `ui_in[1:0]` pads and the PWM generator inside the top-level wrapper.

---
 rtl/button_conditioner.sv | 171 +++++++++++++++++
 tb/tb_button_conditioner.sv | 318 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/button_conditioner.sv
// Duty-adjust button front end: each raw button is synchronised, debounced,
// edge-detected and auto-repeated into single-cycle command pulses.

module button_channel #(
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int REPEAT_DELAY    = 5000000,
  parameter int REPEAT_RATE     = 1250000,
  parameter int CNT_W           = 23
) (
  input  logic clk,
  input  logic rst_n,
  input  logic ena,
  input  logic btn,
  output logic level,
  output logic pulse
);

  localparam logic [CNT_W-1:0] DB_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] DLY_LAST = CNT_W'(REPEAT_DELAY - 1);
  localparam logic [CNT_W-1:0] RPT_LAST = CNT_W'(REPEAT_RATE - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    HOLD   = 2'd1,
    REPEAT = 2'd2
  } state_t;

  logic             sync_a;
  logic             s;
  logic [CNT_W-1:0] dcnt;
  logic [CNT_W-1:0] rcnt;
  state_t           state;
  logic             accept;
  logic             rise;

  // The level flips on the same edge that the counter reaches its last value,
  // so the press pulse is launched alongside the new level.
  assign accept = (s != level) && (dcnt == DB_LAST);
  assign rise   = accept && s;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_a <= 1'b0;
      s      <= 1'b0;
    end else if (ena) begin
      sync_a <= btn;
      s      <= sync_a;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dcnt  <= '0;
      level <= 1'b0;
    end else if (ena) begin
      if (s == level) begin
        dcnt <= '0;
      end else if (accept) begin
        level <= s;
        dcnt  <= '0;
      end else begin
        dcnt <= dcnt + CNT_ONE;
      end
    end
  end

  // Release is judged on the registered level, so the FSM returns to IDLE
  // one cycle after the debounced level falls and never pulses on release.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      rcnt  <= '0;
      pulse <= 1'b0;
    end else if (!ena) begin
      pulse <= 1'b0;
    end else begin
      pulse <= 1'b0;
      case (state)
        IDLE: begin
          if (rise) begin
            pulse <= 1'b1;
            rcnt  <= '0;
            state <= HOLD;
          end
        end
        HOLD: begin
          if (!level) begin
            state <= IDLE;
          end else if ((REPEAT_RATE != 0) && (rcnt == DLY_LAST)) begin
            pulse <= 1'b1;
            rcnt  <= '0;
            state <= REPEAT;
          end else begin
            rcnt <= rcnt + CNT_ONE;
          end
        end
        REPEAT: begin
          if (!level) begin
            state <= IDLE;
          end else if (rcnt == RPT_LAST) begin
            pulse <= 1'b1;
            rcnt  <= '0;
          end else begin
            rcnt <= rcnt + CNT_ONE;
          end
        end
        default: begin
          state <= IDLE;
          rcnt  <= '0;
        end
      endcase
    end
  end

endmodule

module button_conditioner #(
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int REPEAT_DELAY    = 5000000,
  parameter int REPEAT_RATE     = 1250000,
  parameter int CNT_W           = 23
) (
  input  logic clk,
  input  logic rst_n,
  input  logic ena,
  input  logic btn_inc_raw,
  input  logic btn_dec_raw,
  output logic inc_pulse,
  output logic dec_pulse,
  output logic inc_level,
  output logic dec_level
);

  logic inc_raw_pulse;
  logic dec_raw_pulse;

  button_channel #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .REPEAT_DELAY   (REPEAT_DELAY),
    .REPEAT_RATE    (REPEAT_RATE),
    .CNT_W          (CNT_W)
  ) u_inc (
    .clk  (clk),
    .rst_n(rst_n),
    .ena  (ena),
    .btn  (btn_inc_raw),
    .level(inc_level),
    .pulse(inc_raw_pulse)
  );

  button_channel #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .REPEAT_DELAY   (REPEAT_DELAY),
    .REPEAT_RATE    (REPEAT_RATE),
    .CNT_W          (CNT_W)
  ) u_dec (
    .clk  (clk),
    .rst_n(rst_n),
    .ena  (ena),
    .btn  (btn_dec_raw),
    .level(dec_level),
    .pulse(dec_raw_pulse)
  );

  // Both inputs to each mask are flops, so the opposing level used here is the
  // one registered on the same edge as the raw pulse.
  assign inc_pulse = inc_raw_pulse & ~dec_level & ena;
  assign dec_pulse = dec_raw_pulse & ~inc_level & ena;

endmodule

// File: tb/tb_button_conditioner.sv
// Directed bench for button_conditioner: vector table of multi-cycle steps plus
// hand-written sequences for reset, bounce, repeat, conflict, enable and no-repeat.

module tb_button_conditioner;

  localparam int DB  = 4;
  localparam int RD  = 20;
  localparam int RR  = 5;
  localparam int CW  = 8;

  logic clk;
  logic rst_n;
  logic ena;
  logic btn_inc;
  logic btn_dec;
  logic inc_pulse;
  logic dec_pulse;
  logic inc_level;
  logic dec_level;

  logic btn_inc2;
  logic btn_dec2;
  logic nr_inc_pulse;
  logic nr_dec_pulse;
  logic nr_inc_level;
  logic nr_dec_level;

  int tests;
  int fails;
  int cyc;

  logic [31:0] inc_q[$];
  logic [31:0] dec_q[$];
  logic [31:0] nr_q[$];
  logic [31:0] exp_q[$];

  typedef struct {
    logic inc;
    logic dec;
    logic en;
    int   n;
    int   exp_inc;
    int   exp_dec;
    logic exp_il;
    logic exp_dl;
  } vec_t;

  vec_t vecs[16];

  button_conditioner #(
    .DEBOUNCE_CYCLES(DB),
    .REPEAT_DELAY   (RD),
    .REPEAT_RATE    (RR),
    .CNT_W          (CW)
  ) u_dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .ena        (ena),
    .btn_inc_raw(btn_inc),
    .btn_dec_raw(btn_dec),
    .inc_pulse  (inc_pulse),
    .dec_pulse  (dec_pulse),
    .inc_level  (inc_level),
    .dec_level  (dec_level)
  );

  button_conditioner #(
    .DEBOUNCE_CYCLES(DB),
    .REPEAT_DELAY   (RD),
    .REPEAT_RATE    (0),
    .CNT_W          (CW)
  ) u_norep (
    .clk        (clk),
    .rst_n      (rst_n),
    .ena        (ena),
    .btn_inc_raw(btn_inc2),
    .btn_dec_raw(btn_dec2),
    .inc_pulse  (nr_inc_pulse),
    .dec_pulse  (nr_dec_pulse),
    .inc_level  (nr_inc_level),
    .dec_level  (nr_dec_level)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, tests=%0d failed=%0d", tests, fails);
    $fatal(1);
  end

  // driver tasks
  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
    if (inc_pulse)    inc_q.push_back(cyc);
    if (dec_pulse)    dec_q.push_back(cyc);
    if (nr_inc_pulse) nr_q.push_back(cyc);
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic clear_q();
    inc_q.delete();
    dec_q.delete();
    nr_q.delete();
    exp_q.delete();
  endtask

  // scoreboard
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic check_q(input string name, input logic [31:0] got[$], input logic [31:0] exp[$]);
    check({name, "_count"}, got.size(), exp.size());
    for (int i = 0; i < exp.size() && i < got.size(); i++)
      check(name, got[i], exp[i]);
  endtask

  initial begin
    int c0;
    int c1;
    int ni;
    int nd;
    int n;

    tests = 0;
    fails = 0;
    cyc   = 0;
    rst_n = 1'b0;
    ena   = 1'b1;
    btn_inc  = 1'b1;
    btn_dec  = 1'b1;
    btn_inc2 = 1'b0;
    btn_dec2 = 1'b0;

    // ---- reset with both buttons held
    run(3);
    check("rst_outputs", {inc_pulse, dec_pulse, inc_level, dec_level}, 4'b0000);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check("rst_release_outputs", {inc_pulse, dec_pulse, inc_level, dec_level}, 4'b0000);
    end
    btn_dec = 1'b0;
    n = 0;
    while (!inc_level && n < 20) begin
      step();
      n++;
    end
    check("rst_inc_level_up", inc_level, 1'b1);
    check("rst_dec_level_stays", dec_level, 1'b0);

    // asynchronous reset mid-cycle
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_inc_level", inc_level, 1'b0);
    check("async_rst_inc_pulse", inc_pulse, 1'b0);
    run(2);
    rst_n = 1'b1;
    clear_q();
    for (int i = 0; i < 5; i++) begin
      step();
      check("post_rst_quiet", {inc_pulse, inc_level}, 2'b00);
    end
    step();
    check("post_rst_fresh_press", {inc_pulse, inc_level}, 2'b11);
    btn_inc = 1'b0;
    run(12);

    // ---- table-driven vectors
    vecs[0]  = '{1'b0, 1'b0, 1'b1, 10, 0, 0, 1'b0, 1'b0};
    vecs[1]  = '{1'b1, 1'b0, 1'b1,  6, 1, 0, 1'b1, 1'b0};
    vecs[2]  = '{1'b1, 1'b0, 1'b1, 14, 0, 0, 1'b1, 1'b0};
    vecs[3]  = '{1'b1, 1'b0, 1'b1,  6, 1, 0, 1'b1, 1'b0};
    vecs[4]  = '{1'b1, 1'b0, 1'b1, 10, 2, 0, 1'b1, 1'b0};
    vecs[5]  = '{1'b0, 1'b0, 1'b1,  5, 1, 0, 1'b1, 1'b0};
    vecs[6]  = '{1'b0, 1'b0, 1'b1,  6, 0, 0, 1'b0, 1'b0};
    vecs[7]  = '{1'b0, 1'b1, 1'b1,  6, 0, 1, 1'b0, 1'b1};
    vecs[8]  = '{1'b0, 1'b0, 1'b1,  3, 0, 0, 1'b0, 1'b1};
    vecs[9]  = '{1'b0, 1'b1, 1'b1, 20, 0, 1, 1'b0, 1'b1};
    vecs[10] = '{1'b0, 1'b0, 1'b1, 12, 0, 1, 1'b0, 1'b0};
    vecs[11] = '{1'b0, 1'b0, 1'b0,  5, 0, 0, 1'b0, 1'b0};
    vecs[12] = '{1'b1, 1'b0, 1'b0, 10, 0, 0, 1'b0, 1'b0};
    vecs[13] = '{1'b1, 1'b0, 1'b1,  6, 1, 0, 1'b1, 1'b0};
    vecs[14] = '{1'b0, 1'b0, 1'b1, 12, 0, 0, 1'b0, 1'b0};
    vecs[15] = '{1'b0, 1'b0, 1'b1,  4, 0, 0, 1'b0, 1'b0};

    for (int v = 0; v < 16; v++) begin
      btn_inc = vecs[v].inc;
      btn_dec = vecs[v].dec;
      ena     = vecs[v].en;
      ni = 0;
      nd = 0;
      for (int k = 0; k < vecs[v].n; k++) begin
        step();
        ni += int'(inc_pulse);
        nd += int'(dec_pulse);
      end
      check($sformatf("vec%0d_inc_pulses", v), ni, vecs[v].exp_inc);
      check($sformatf("vec%0d_dec_pulses", v), nd, vecs[v].exp_dec);
      check($sformatf("vec%0d_inc_level", v), inc_level, vecs[v].exp_il);
      check($sformatf("vec%0d_dec_level", v), dec_level, vecs[v].exp_dl);
    end
    ena = 1'b1;
    run(4);

    // ---- bounce: 30 cycles of 2-cycle toggling, then a held press
    clear_q();
    for (int i = 0; i < 15; i++) begin
      btn_inc = (i % 2 == 1);
      run(2);
    end
    btn_inc = 1'b1;
    c0 = cyc;
    run(5);
    check("bounce_level_before", inc_level, 1'b0);
    step();
    check("bounce_level_with_pulse", {inc_pulse, inc_level}, 2'b11);
    run(10);
    exp_q.push_back(c0 + 6);
    check_q("bounce_inc_times", inc_q, exp_q);
    btn_inc = 1'b0;
    run(12);

    // ---- auto-repeat on dec, then a re-press to show the FSM returned to IDLE
    clear_q();
    btn_dec = 1'b1;
    c0 = cyc;
    run(58);
    btn_dec = 1'b0;
    run(5);
    check("repeat_level_before_fall", dec_level, 1'b1);
    step();
    check("repeat_level_after_fall", dec_level, 1'b0);
    run(15);
    btn_dec = 1'b1;
    c1 = cyc;
    run(8);
    btn_dec = 1'b0;
    run(12);
    exp_q.push_back(c0 + 6);
    for (int t = 26; t <= 61; t += 5) exp_q.push_back(c0 + t);
    exp_q.push_back(c1 + 6);
    check_q("repeat_dec_times", dec_q, exp_q);
    check("repeat_inc_quiet", inc_q.size(), 0);

    // ---- conflict: inc held, dec joins then leaves
    clear_q();
    btn_inc = 1'b1;
    c0 = cyc;
    run(10);
    btn_dec = 1'b1;
    run(10);
    check("conflict_both_levels", {inc_level, dec_level}, 2'b11);
    run(22);
    btn_dec = 1'b0;
    run(16);
    btn_inc = 1'b0;
    run(17);
    exp_q.push_back(c0 + 6);
    exp_q.push_back(c0 + 51);
    exp_q.push_back(c0 + 56);
    exp_q.push_back(c0 + 61);
    check_q("conflict_inc_times", inc_q, exp_q);
    check("conflict_dec_count", dec_q.size(), 0);

    // ---- ena low for 7 cycles inside REPEAT
    clear_q();
    btn_inc = 1'b1;
    c0 = cyc;
    run(33);
    ena = 1'b0;
    for (int i = 0; i < 7; i++) begin
      step();
      check("ena_low_frozen", {inc_pulse, inc_level}, 2'b01);
    end
    ena = 1'b1;
    run(10);
    btn_inc = 1'b0;
    run(15);
    exp_q.push_back(c0 + 6);
    exp_q.push_back(c0 + 26);
    exp_q.push_back(c0 + 31);
    exp_q.push_back(c0 + 43);
    exp_q.push_back(c0 + 48);
    exp_q.push_back(c0 + 53);
    check_q("ena_inc_times", inc_q, exp_q);

    // ---- repeat disabled instance
    clear_q();
    btn_inc2 = 1'b1;
    c0 = cyc;
    run(100);
    check("norep_level_held", nr_inc_level, 1'b1);
    btn_inc2 = 1'b0;
    run(12);
    exp_q.push_back(c0 + 6);
    check_q("norep_inc_times", nr_q, exp_q);
    check("norep_level_released", nr_inc_level, 1'b0);

    // final report
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
